// File: rtl/inst_mem_bank.sv
// Instruction-memory bank for the Mini-core fetch path.
// One synchronous read port (1-cycle latency, valid strobe) and one write port,
// both usable in the same cycle. A clear engine zeroes the array after reset
// (INIT_CLEAR=1) or on clr_req; accesses during a clear and out-of-range
// accesses are reported on access_err.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   wr_en      write request        wr_addr/wr_data  write address/data
//   rd_en      read request         rd_addr          read address
//   clr_req    single-cycle request to zero the whole array
//   rd_data    registered read data
//   rd_valid   one-cycle pulse: rd_data updated
//   busy       clear engine active, all accesses dropped
//   access_err one-cycle pulse: dropped or illegal access in the previous cycle
module inst_mem_bank #(
   parameter int unsigned DATA_W     = 20,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned RDW_MODE   = 0,
   parameter int unsigned INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              clr_req,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              access_err
);

   localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic [ADDR_W-1:0]   w_clr_ptr_nxt;
   logic [DATA_W-1:0]   r_rd_data;
   logic [DATA_W-1:0]   w_rd_data_nxt;
   logic                r_rd_valid;
   logic                w_rd_valid_nxt;
   logic                r_access_err;
   logic                w_access_err_nxt;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                w_mem_we;
   logic [IDX_W-1:0]    w_mem_idx;
   logic [DATA_W-1:0]   w_mem_wdata;

   logic                w_wr_ok;
   logic                w_rd_ok;
   logic                w_bypass;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [IDX_W-1:0]    w_rd_idx;

   // Address decode: range check in 32 bits so DEPTH=2**ADDR_W stays well-formed
   assign w_wr_ok  = (32'(wr_addr) < DEPTH);
   assign w_rd_ok  = (32'(rd_addr) < DEPTH);
   assign w_wr_idx = IDX_W'(wr_addr);
   assign w_rd_idx = IDX_W'(rd_addr);
   // Write-through only when the same valid word is written and read together
   assign w_bypass = (RDW_MODE == 1) && wr_en && w_wr_ok && (wr_addr == rd_addr);

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= (INIT_CLEAR == 1) ? ST_CLEAR : ST_IDLE;
         r_clr_ptr    <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
         r_access_err <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_ptr    <= w_clr_ptr_nxt;
         r_rd_data    <= w_rd_data_nxt;
         r_rd_valid   <= w_rd_valid_nxt;
         r_access_err <= w_access_err_nxt;
      end
   end

   // Next-state, clear sequencing, memory write select and read result
   always_comb begin
      w_state_nxt      = r_state;
      w_clr_ptr_nxt    = r_clr_ptr;
      w_rd_data_nxt    = r_rd_data;
      w_rd_valid_nxt   = 1'b0;
      w_access_err_nxt = 1'b0;
      w_mem_we         = 1'b0;
      w_mem_idx        = w_wr_idx;
      w_mem_wdata      = wr_data;
      case (r_state)
         ST_IDLE: begin
            w_mem_we = wr_en && w_wr_ok;
            if (rd_en) begin
               w_rd_valid_nxt = 1'b1;
               if (!w_rd_ok)     w_rd_data_nxt = '0;
               else if (w_bypass) w_rd_data_nxt = wr_data;
               else              w_rd_data_nxt = r_mem[w_rd_idx];
            end
            w_access_err_nxt = (wr_en && !w_wr_ok) || (rd_en && !w_rd_ok);
            if (clr_req) w_state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            // One word zeroed per cycle; user accesses are dropped and flagged
            w_mem_we         = 1'b1;
            w_mem_idx        = IDX_W'(r_clr_ptr);
            w_mem_wdata      = '0;
            w_access_err_nxt = wr_en || rd_en;
            if (r_clr_ptr == LAST_ADDR) begin
               w_state_nxt   = ST_IDLE;
               w_clr_ptr_nxt = '0;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_clr_ptr_nxt = '0;
         end
      endcase
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
   end

   assign rd_data    = r_rd_data;
   assign rd_valid   = r_rd_valid;
   assign busy       = (r_state == ST_CLEAR);
   assign access_err = r_access_err;

endmodule

// File: tb/tb_inst_mem_bank.sv
// Directed testbench for inst_mem_bank: three instances share stimulus
// (a: defaults, b: RDW_MODE=1, c: DEPTH=20) and each task checks one feature.
module tb_inst_mem_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [19:0] wr_data;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic        clr_req;

   logic [19:0] a_rd_data, b_rd_data, c_rd_data;
   logic        a_rd_valid, b_rd_valid, c_rd_valid;
   logic        a_busy, b_busy, c_busy;
   logic        a_access_err, b_access_err, c_access_err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   inst_mem_bank #(.DATA_W(20), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0), .INIT_CLEAR(1)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy), .access_err(a_access_err));

   inst_mem_bank #(.DATA_W(20), .ADDR_W(5), .DEPTH(32), .RDW_MODE(1), .INIT_CLEAR(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy), .access_err(b_access_err));

   inst_mem_bank #(.DATA_W(20), .ADDR_W(5), .DEPTH(20), .RDW_MODE(0), .INIT_CLEAR(1)) dut_c (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
      .rd_data(c_rd_data), .rd_valid(c_rd_valid), .busy(c_busy), .access_err(c_access_err));

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int a_fall;
      int c_fall;
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
      tick; tick;
      n_total++; if (a_rd_data !== 20'h0) $display("FAIL reset_rd_data: got %h want 00000", a_rd_data); else n_pass++;
      n_total++; if (a_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", a_rd_valid); else n_pass++;
      n_total++; if (a_access_err !== 1'b0) $display("FAIL reset_access_err: got %b want 0", a_access_err); else n_pass++;
      n_total++; if (a_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", a_busy); else n_pass++;
      rst = 1'b1;
      a_fall = 0; c_fall = 0;
      for (int k = 1; k <= 100; k++) begin
         tick;
         if (c_fall == 0 && c_busy === 1'b0) c_fall = k;
         if (a_busy === 1'b0) begin
            a_fall = k;
            break;
         end
      end
      n_total++; if (a_fall != 32) $display("FAIL init_clear_len32: busy fell after %0d edges want 32", a_fall); else n_pass++;
      n_total++; if (c_fall != 20) $display("FAIL init_clear_len20: busy fell after %0d edges want 20", c_fall); else n_pass++;
   endtask

   task automatic test_clear_zero;
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         rd_en = 1'b1; rd_addr = 5'(i);
         tick;
         if (a_rd_valid !== 1'b1 || a_rd_data !== 20'h0) bad++;
      end
      rd_en = 1'b0;
      n_total++; if (bad != 0) $display("FAIL clear_zero_reads: %0d bad reads want 0", bad); else n_pass++;
      tick;
      n_total++; if (a_rd_valid !== 1'b0) $display("FAIL idle_rd_valid: got %b want 0", a_rd_valid); else n_pass++;
   endtask

   task automatic test_write_read;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 20'hABCDE;
      tick;
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd7;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'hABCDE) $display("FAIL wr_rd_data: got %h want abcde", a_rd_data); else n_pass++;
      n_total++; if (a_rd_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", a_rd_valid); else n_pass++;
      tick; tick;
      n_total++; if (a_rd_data !== 20'hABCDE) $display("FAIL rd_hold_data: got %h want abcde", a_rd_data); else n_pass++;
      n_total++; if (a_rd_valid !== 1'b0) $display("FAIL rd_hold_valid: got %b want 0", a_rd_valid); else n_pass++;
   endtask

   task automatic test_rdw;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 20'h11111;
      tick;
      wr_data = 20'h22222; rd_en = 1'b1; rd_addr = 5'd3;
      tick;
      wr_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h11111) $display("FAIL rdw_old: got %h want 11111", a_rd_data); else n_pass++;
      n_total++; if (b_rd_data !== 20'h22222) $display("FAIL rdw_new: got %h want 22222", b_rd_data); else n_pass++;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h22222) $display("FAIL rdw_after_old: got %h want 22222", a_rd_data); else n_pass++;
      n_total++; if (b_rd_data !== 20'h22222) $display("FAIL rdw_after_new: got %h want 22222", b_rd_data); else n_pass++;
   endtask

   task automatic test_back_to_back;
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 20'h0A0A0;
      tick;
      wr_addr = 5'd11; wr_data = 20'h0B0B0; rd_en = 1'b1; rd_addr = 5'd10;
      tick;
      wr_en = 1'b0; rd_addr = 5'd11;
      n_total++; if (a_rd_data !== 20'h0A0A0 || a_rd_valid !== 1'b1) $display("FAIL b2b_first: got %h/%b want 0a0a0/1", a_rd_data, a_rd_valid); else n_pass++;
      n_total++; if (b_rd_data !== 20'h0A0A0) $display("FAIL b2b_diff_addr_bypass: got %h want 0a0a0", b_rd_data); else n_pass++;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h0B0B0 || a_rd_valid !== 1'b1) $display("FAIL b2b_second: got %h/%b want 0b0b0/1", a_rd_data, a_rd_valid); else n_pass++;
      n_total++; if (a_access_err !== 1'b0) $display("FAIL b2b_no_err: got %b want 0", a_access_err); else n_pass++;
   endtask

   task automatic test_clear_access;
      int e;
      clr_req = 1'b1;
      tick;
      clr_req = 1'b0; e = 0;
      n_total++; if (a_busy !== 1'b1) $display("FAIL clr_start_busy: got %b want 1", a_busy); else n_pass++;
      repeat (4) tick;
      rd_en = 1'b1; rd_addr = 5'd7;
      tick; e = 5;
      rd_en = 1'b0;
      n_total++; if (a_access_err !== 1'b1) $display("FAIL clr_access_err: got %b want 1", a_access_err); else n_pass++;
      n_total++; if (a_rd_valid !== 1'b0) $display("FAIL clr_rd_valid: got %b want 0", a_rd_valid); else n_pass++;
      n_total++; if (a_rd_data !== 20'h0B0B0) $display("FAIL clr_rd_hold: got %h want 0b0b0", a_rd_data); else n_pass++;
      tick; e = 6;
      n_total++; if (a_access_err !== 1'b0) $display("FAIL clr_err_not_sticky: got %b want 0", a_access_err); else n_pass++;
      repeat (3) tick;
      clr_req = 1'b1;
      tick; e = 10;
      clr_req = 1'b0;
      while (a_busy === 1'b1 && e < 100) begin
         tick; e++;
      end
      n_total++; if (e != 32) $display("FAIL clr_len_no_restart: busy fell at edge %0d want 32", e); else n_pass++;
      rd_en = 1'b1; rd_addr = 5'd7;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h0 || a_rd_valid !== 1'b1) $display("FAIL clr_zeroed: got %h/%b want 00000/1", a_rd_data, a_rd_valid); else n_pass++;
   endtask

   task automatic test_out_of_range;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 20'h5A5A5;
      tick;
      wr_addr = 5'd25; wr_data = 20'h12345;
      tick;
      wr_en = 1'b0;
      n_total++; if (c_access_err !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", c_access_err); else n_pass++;
      n_total++; if (a_access_err !== 1'b0) $display("FAIL inrange_wr_no_err: got %b want 0", a_access_err); else n_pass++;
      tick;
      n_total++; if (c_access_err !== 1'b0) $display("FAIL oor_err_pulse: got %b want 0", c_access_err); else n_pass++;
      rd_en = 1'b1; rd_addr = 5'd4;
      tick;
      rd_addr = 5'd25;
      n_total++; if (c_rd_data !== 20'h5A5A5) $display("FAIL oor_array_kept: got %h want 5a5a5", c_rd_data); else n_pass++;
      tick;
      rd_addr = 5'd9;
      n_total++; if (c_rd_data !== 20'h0 || c_rd_valid !== 1'b1 || c_access_err !== 1'b1)
         $display("FAIL oor_rd: got %h/%b/%b want 00000/1/1", c_rd_data, c_rd_valid, c_access_err); else n_pass++;
      n_total++; if (a_rd_data !== 20'h12345 || a_access_err !== 1'b0) $display("FAIL inrange_rd25: got %h/%b want 12345/0", a_rd_data, a_access_err); else n_pass++;
      tick;
      rd_en = 1'b0;
      n_total++; if (c_rd_data !== 20'h0 || c_access_err !== 1'b0) $display("FAIL oor_no_alias: got %h/%b want 00000/0", c_rd_data, c_access_err); else n_pass++;
   endtask

   task automatic test_reset_mid_clear;
      int e;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 20'h77777;
      tick;
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd2;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h77777) $display("FAIL pre_reset_rd: got %h want 77777", a_rd_data); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (a_rd_data !== 20'h0 || a_rd_valid !== 1'b0) $display("FAIL async_reset: got %h/%b want 00000/0", a_rd_data, a_rd_valid); else n_pass++;
      tick;
      rst = 1'b1;
      repeat (9) tick;
      rst = 1'b0;
      repeat (3) tick;
      n_total++; if (a_rd_data !== 20'h0 || a_rd_valid !== 1'b0 || a_busy !== 1'b1)
         $display("FAIL mid_clear_reset: got %h/%b/%b want 00000/0/1", a_rd_data, a_rd_valid, a_busy); else n_pass++;
      rst = 1'b1;
      e = 0;
      while (a_busy === 1'b1 && e < 100) begin
         tick; e++;
      end
      n_total++; if (e != 32) $display("FAIL restart_clear_len: busy fell after %0d edges want 32", e); else n_pass++;
      rd_en = 1'b1; rd_addr = 5'd2;
      tick;
      rd_en = 1'b0;
      n_total++; if (a_rd_data !== 20'h0 || a_rd_valid !== 1'b1) $display("FAIL restart_zeroed: got %h/%b want 00000/1", a_rd_data, a_rd_valid); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_clear_zero;
      test_write_read;
      test_rdw;
      test_back_to_back;
      test_clear_access;
      test_out_of_range;
      test_reset_mid_clear;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_mem_bank.md
Name: inst_mem_bank

Overview:
Parametrised instruction-memory bank for the Mini-core fetch path. It provides one synchronous read port and one write port that can both be used in the same cycle. Reads have a fixed one-cycle latency with a valid strobe. A built-in clear engine zeroes the array after reset or on request, and illegal or blocked accesses are flagged.

Parameters:
DATA_W, 20, instruction word width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (write-through bypass)
INIT_CLEAR, 1, 1 = run the clear engine automatically after reset; 0 = array contents undefined after reset

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
clr_req  input  1  single-cycle request to zero the whole array
rd_data  output  DATA_W  registered read data
rd_valid  output  1  rd_data updated this cycle (one-cycle pulse)
busy  output  1  clear engine active; all accesses blocked
access_err  output  1  one-cycle pulse reporting a dropped or illegal access

Behaviour:
- Reset (rst=0, async): rd_data=0, rd_valid=0, access_err=0, clr_ptr=0.
  - State goes to CLEAR if INIT_CLEAR=1, otherwise IDLE; busy follows state, so it is 1 or 0 respectively.
  - The array itself is not reset.
- State machine has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - CLEAR -> IDLE after the edge that writes address DEPTH-1.
  - busy=1 exactly while in CLEAR.
- CLEAR timing: one word per cycle, zero written to mem[clr_ptr], then clr_ptr increments.
  - The first write happens on the first rising edge after rst deasserts, or on the edge after the one that sampled clr_req.
  - A clear takes exactly DEPTH cycles; busy drops after the DEPTH-th write edge.
- clr_req while in CLEAR is ignored: no restart, no error.
- Reset asserted mid-clear aborts it; with INIT_CLEAR=1 the clear restarts from address 0 after release.
- Accesses during CLEAR: any wr_en or rd_en is dropped.
  - access_err=1 on the following cycle.
  - rd_valid stays 0 and rd_data holds its value.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): mem[wr_addr] <= wr_data on the same edge.
- Read (IDLE, rd_en=1, rd_addr<DEPTH): request at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+1.
  - Latency is exactly 1.
  - Back-to-back reads sustain one result per cycle.
  - When no read completes, rd_data holds its last value and rd_valid=0.
- Same-cycle read and write to different addresses: both complete independently.
- Same-cycle read and write to the same address:
  - RDW_MODE=0: rd_data = value before the write.
  - RDW_MODE=1: rd_data = wr_data.
  - The array is updated in both modes.
- Out-of-range access (address >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Write: ignored, access_err pulses.
  - Read: rd_data=0, rd_valid=1, access_err pulses.
- access_err is one cycle after the offending request and is 1 if any request in that cycle was bad. It is not sticky.
- clr_req in the same IDLE cycle as an access: the access is served normally, then CLEAR starts.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset with INIT_CLEAR=1, DEPTH=32, then release rst → busy=1 for exactly 32 cycles, then 0.
  - Afterwards, reading addresses 0..31 returns 0x00000 each, with rd_valid one cycle after each rd_en.
- Write 0xABCDE to address 7, then rd_en with rd_addr=7 on the next cycle → rd_data=0xABCDE with rd_valid=1 exactly one cycle later.
  - rd_data still holds 0xABCDE two cycles later, with rd_valid=0.
- mem[3]=0x11111, then same cycle wr_en addr 3 data 0x22222 and rd_en addr 3 → rd_data=0x11111 with RDW_MODE=0, 0x22222 with RDW_MODE=1.
  - A following read of addr 3 returns 0x22222 in both modes.
- Pulse clr_req, then assert rd_en on cycle 5 of the clear → access_err=1 on the next cycle, rd_valid=0.
  - clr_req again on cycle 10 does not extend the clear: busy falls at cycle 32.
- DEPTH=20, ADDR_W=5: write to addr 25 → access_err pulse, array unchanged; read addr 25 → rd_data=0, rd_valid=1, access_err=1.
- Assert rst at cycle 10 of the post-reset clear, hold for 3 cycles, then release → rd_data=0 and rd_valid=0 during reset.
  - busy=1 for exactly 32 cycles after release.
